rmii_rx: RTL and testbench
==========================

Name: rmii_rx

Overview:
RMII receive front end of the MAC, running in the clk_mac (50 MHz) domain. It sits directly downstream of the PHY pins eth_crsdv, eth_rxd and eth_rxerr, which are driven by the simulated PHY in simulation.
- Deserialises dibits into bytes.
- Strips the preamble and SFD.
- Runs CRC-32 and length checks.
- Emits a byte stream with sof/eof markers and a status word to the MAC receive buffer.

Parameters:
MIN_LEN, 64, minimum legal frame length in bytes (DA through FCS inclusive).
MAX_LEN, 1522, maximum legal frame length in bytes (VLAN tagged).
LEN_W, 11, width of the byte counter and of m_len.

Ports:
clk_mac  in  1  50 MHz RMII reference clock; all logic on posedge.
rst  in  1  asynchronous, active-high reset.
eth_crsdv  in  1  RMII carrier sense / data valid (may toggle at end of frame).
eth_rxd  in  2  RMII receive dibit, LSB-first.
eth_rxerr  in  1  PHY receive error.
m_data  out  8  received byte (FCS bytes included).
m_valid  out  1  m_data valid; single-cycle beats, no backpressure.
m_sof  out  1  first byte of frame; qualified by m_valid.
m_eof  out  1  last byte of frame; qualified by m_valid.
m_status  out  4  valid on the eof beat: [0] crc_err, [1] len_err, [2] phy_err, [3] align_err.
m_len  out  LEN_W  byte count including FCS; valid on the eof beat; saturates at 2^LEN_W-1.

Behaviour:
- Reset (async): state=IDLE; all outputs 0; CRC register = 0xFFFFFFFF; counters 0.
- Reset mid-frame: frame is abandoned and no eof beat is emitted.
- Inputs are sampled on posedge clk_mac. No input synchroniser is used; the inputs are in the same clock domain.

State machine:
- IDLE: wait for eth_crsdv=1, then go to PREAMBLE.
- PREAMBLE, per sampled cycle:
  - crsdv=0 → IDLE, no output.
  - rxd=2'b00 or 2'b01 → stay.
  - rxd=2'b11 (SFD final dibit) → DATA with dibit index=0, CRC=0xFFFFFFFF, len=0, flags clear.
  - rxd=2'b10 → DROP.
- DATA, dibit index i in 0..3:
  - Assembly is LSB-first: byte[2i+1:2i] = rxd.
  - End detection: crsdv=0 at an odd index (1 or 3) ends the frame. crsdv=0 at an even index is accepted as data (RMII toggling).
  - End at i=1: the partial byte is discarded; frame closes cleanly.
  - End at i=3: the partial byte is discarded and align_err is set.
  - eth_rxerr=1 on any DATA cycle sets phy_err.
  - On i=3 with crsdv=1: byte complete; CRC updated; len incremented (saturating).
- DROP: wait for crsdv=0 at any cycle, then IDLE. No output.

Output pipeline (one-byte hold register):
- A completed byte enters the hold register.
- The previous held byte is emitted (m_valid=1) on the cycle after the next byte completes.
- On end detection, the held byte is emitted on the next cycle with m_eof=1, m_status and m_len.
- The first emitted beat carries m_sof=1.
- A 1-byte frame emits a single beat with sof=eof=1.
- End with no bytes completed: no output; return to IDLE.

Checks and timing:
- CRC: reflected polynomial 0xEDB88320, init 0xFFFFFFFF, computed over all bytes including FCS. crc_err = (final register != 0xDEBB20E3).
- len_err = (len < MIN_LEN) or (len > MAX_LEN). All bytes are still forwarded.
- End-to-eof latency: 1 cycle. Back-to-back frames need at least one crsdv=0 cycle, which the PHY guarantees through the IPG.

Decomposition:
- Package eth_pkg holds:
  - CRC32_POLY, CRC32_INIT, CRC32_RESIDUE.
  - SFD dibit and preamble dibit constants.
  - Status bit indices (ST_CRC, ST_LEN, ST_PHY, ST_ALIGN).
  - The state enum typedef.
- Sub-module crc32_d2: combinational 2-bit-per-step CRC-32 update (crc_in, dibit → crc_out). It is reusable by the transmit FCS generator.

Test Plan:
- 7×0x55, 0xD5, then a 64-byte frame with valid FCS, crsdv low at a byte boundary → 64 beats, sof on beat 0, eof on beat 63, m_len=64, m_status=4'b0000.
- 14-byte frame (DA=ff..ff, SA=00..00, type 0xebeb) with no FCS → 14 beats, m_len=14, m_status[1:0]=2'b11 (len and CRC error).
- Valid 64-byte frame with crsdv toggling (low on even, high on odd dibits) during the last 4 bytes → identical data output, status 0.
- eth_rxerr pulsed 1 cycle mid-frame → phy_err=1, all bytes still delivered.
- crsdv drops at dibit index 3 after 65 full bytes → 65 beats, align_err=1.
- rst asserted while byte 20 is being received → outputs 0 immediately, no eof. The next valid frame is received correctly.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared Ethernet constants and types for the RMII receive and transmit paths.
package eth_pkg;

  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

  localparam logic [1:0] DIBIT_PRE = 2'b01;
  localparam logic [1:0] DIBIT_SFD = 2'b11;
  localparam logic [1:0] DIBIT_BAD = 2'b10;

  localparam int ST_CRC   = 0;
  localparam int ST_LEN   = 1;
  localparam int ST_PHY   = 2;
  localparam int ST_ALIGN = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREAMBLE,
    S_DATA,
    S_DROP
  } rx_state_t;

  // One bit of the reflected CRC-32 shift register.
  function automatic logic [31:0] crc32_bit(input logic [31:0] crc, input logic d);
    crc32_bit = {1'b0, crc[31:1]} ^ ((crc[0] ^ d) ? CRC32_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/crc32_d2.sv
// Combinational CRC-32 update for one RMII dibit, bit 0 first.
module crc32_d2
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [1:0]  dibit,
  output logic [31:0] crc_out
);

  always_comb begin
    crc_out = crc32_bit(crc32_bit(crc_in, dibit[0]), dibit[1]);
  end

endmodule

// File: rtl/rmii_rx.sv
// RMII receive front end: dibit-to-byte assembly, preamble/SFD strip, CRC and length checks,
// byte stream with sof/eof and status through a one-byte hold register (end-to-eof latency 1).
module rmii_rx
  import eth_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1522,
  parameter int LEN_W   = 11
) (
  input  logic             clk_mac,
  input  logic             rst,
  input  logic             eth_crsdv,
  input  logic [1:0]       eth_rxd,
  input  logic             eth_rxerr,
  output logic [7:0]       m_data,
  output logic             m_valid,
  output logic             m_sof,
  output logic             m_eof,
  output logic [3:0]       m_status,
  output logic [LEN_W-1:0] m_len
);

  localparam logic [LEN_W-1:0] MIN_L = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

  rx_state_t        r_state;
  logic [1:0]       r_idx;
  logic [5:0]       r_part;
  logic [31:0]      r_crc;
  logic [LEN_W-1:0] r_len;
  logic             r_phy;
  logic [7:0]       r_hold;
  logic             r_hold_vld;
  logic             r_sof_pend;

  logic [7:0]       w_byte;
  logic [31:0]      w_crc [0:4];
  logic [LEN_W-1:0] w_len_inc;
  logic             w_end;
  logic             w_phy;
  logic [3:0]       w_status;

  assign w_byte    = {eth_rxd, r_part};
  assign w_len_inc = (r_len == {LEN_W{1'b1}}) ? r_len : r_len + LEN_W'(1);
  // Carrier may drop on even dibits as RMII toggling; only an odd-index drop ends the frame.
  assign w_end     = ~eth_crsdv & r_idx[0];
  assign w_phy     = r_phy | eth_rxerr;
  assign w_crc[0]  = r_crc;

  for (genvar k = 0; k < 4; k++) begin : g_crc
    crc32_d2 u_crc (
      .crc_in (w_crc[k]),
      .dibit  (w_byte[2*k +: 2]),
      .crc_out(w_crc[k+1])
    );
  end

  always_comb begin
    w_status           = 4'b0000;
    w_status[ST_CRC]   = (r_crc != CRC32_RESIDUE);
    w_status[ST_LEN]   = (r_len < MIN_L) || (r_len > MAX_L);
    w_status[ST_PHY]   = w_phy;
    w_status[ST_ALIGN] = (r_idx == 2'd3);
  end

  always_ff @(posedge clk_mac or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_idx      <= 2'd0;
      r_part     <= 6'd0;
      r_crc      <= CRC32_INIT;
      r_len      <= '0;
      r_phy      <= 1'b0;
      r_hold     <= 8'd0;
      r_hold_vld <= 1'b0;
      r_sof_pend <= 1'b0;
      m_data     <= 8'd0;
      m_valid    <= 1'b0;
      m_sof      <= 1'b0;
      m_eof      <= 1'b0;
      m_status   <= 4'd0;
      m_len      <= '0;
    end else begin
      m_valid  <= 1'b0;
      m_sof    <= 1'b0;
      m_eof    <= 1'b0;
      m_status <= 4'd0;
      m_len    <= '0;
      case (r_state)
        S_IDLE: begin
          if (eth_crsdv) r_state <= S_PREAMBLE;
        end
        S_PREAMBLE: begin
          if (!eth_crsdv) begin
            r_state <= S_IDLE;
          end else begin
            case (eth_rxd)
              DIBIT_SFD: begin
                r_state    <= S_DATA;
                r_idx      <= 2'd0;
                r_crc      <= CRC32_INIT;
                r_len      <= '0;
                r_phy      <= 1'b0;
                r_hold_vld <= 1'b0;
                r_sof_pend <= 1'b1;
              end
              DIBIT_BAD: r_state <= S_DROP;
              default:   r_state <= S_PREAMBLE;
            endcase
          end
        end
        S_DATA: begin
          r_phy <= w_phy;
          if (w_end) begin
            r_state    <= S_IDLE;
            r_hold_vld <= 1'b0;
            if (r_hold_vld) begin
              m_valid  <= 1'b1;
              m_data   <= r_hold;
              m_sof    <= r_sof_pend;
              m_eof    <= 1'b1;
              m_status <= w_status;
              m_len    <= r_len;
            end
          end else begin
            r_idx <= r_idx + 2'd1;
            case (r_idx)
              2'd0: r_part[1:0] <= eth_rxd;
              2'd1: r_part[3:2] <= eth_rxd;
              2'd2: r_part[5:4] <= eth_rxd;
              default: begin
                r_crc      <= w_crc[4];
                r_len      <= w_len_inc;
                r_hold     <= w_byte;
                r_hold_vld <= 1'b1;
                if (r_hold_vld) begin
                  m_valid    <= 1'b1;
                  m_data     <= r_hold;
                  m_sof      <= r_sof_pend;
                  r_sof_pend <= 1'b0;
                end
              end
            endcase
          end
        end
        default: begin
          if (!eth_crsdv) r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rmii_rx.sv
// Directed bench for rmii_rx: drives RMII dibits on negedge, captures beats on negedge.
module tb_rmii_rx;

  logic        clk_mac = 1'b0;
  logic        rst = 1'b1;
  logic        eth_crsdv = 1'b0;
  logic [1:0]  eth_rxd = 2'b00;
  logic        eth_rxerr = 1'b0;
  logic [7:0]  m_data;
  logic        m_valid, m_sof, m_eof;
  logic [3:0]  m_status;
  logic [10:0] m_len;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0]  d;
    logic        sof;
    logic        eof;
    logic [3:0]  st;
    logic [10:0] len;
  } beat_t;

  beat_t      beats[$];
  logic [7:0] tx_q[$];

  rmii_rx #(.MIN_LEN(64), .MAX_LEN(1522), .LEN_W(11)) dut (
    .clk_mac  (clk_mac),
    .rst      (rst),
    .eth_crsdv(eth_crsdv),
    .eth_rxd  (eth_rxd),
    .eth_rxerr(eth_rxerr),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_sof    (m_sof),
    .m_eof    (m_eof),
    .m_status (m_status),
    .m_len    (m_len)
  );

  always #10 clk_mac = ~clk_mac;

  always @(negedge clk_mac) begin
    if (m_valid) beats.push_back('{m_data, m_sof, m_eof, m_status, m_len});
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_dibit(input logic c, input logic [1:0] d, input logic e);
    @(negedge clk_mac);
    eth_crsdv = c;
    eth_rxd   = d;
    eth_rxerr = e;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit tog, input bit err);
    for (int k = 0; k < 4; k++)
      send_dibit(tog ? (k % 2 == 1) : 1'b1, b[2*k +: 2], err && (k == 1));
  endtask

  task automatic send_preamble();
    for (int i = 0; i < 7; i++) send_byte(8'h55, 0, 0);
    send_byte(8'hD5, 0, 0);
  endtask

  task automatic send_gap(input int n);
    for (int i = 0; i < n; i++) send_dibit(1'b0, 2'b00, 1'b0);
  endtask

  // Frame body from tx_q; optional carrier toggling over the last 4 bytes and an rxerr pulse.
  task automatic send_frame(input bit tog_last4, input int err_byte);
    send_preamble();
    for (int i = 0; i < tx_q.size(); i++)
      send_byte(tx_q[i], tog_last4 && (i >= tx_q.size() - 4), i == err_byte);
    send_gap(10);
  endtask

  function automatic logic [31:0] fcs_of(input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, tx_q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic build_frame(input int n_payload, input int seed);
    logic [31:0] f;
    tx_q.delete();
    for (int i = 0; i < n_payload; i++) tx_q.push_back(8'((i * 7 + seed) & 255));
    f = fcs_of(n_payload);
    for (int b = 0; b < 4; b++) tx_q.push_back(f[8*b +: 8]);
  endtask

  task automatic check_frame(input string tag, input logic [3:0] exp_st, input int exp_len);
    int nbad, nsof, neof, n;
    nbad = 0; nsof = 0; neof = 0;
    n = beats.size();
    chk({tag, "_beats"}, n, tx_q.size());
    for (int i = 0; i < n && i < tx_q.size(); i++) begin
      if (beats[i].d !== tx_q[i]) nbad++;
      if (beats[i].sof) nsof++;
      if (beats[i].eof) neof++;
    end
    chk({tag, "_data_bad"}, nbad, 0);
    chk({tag, "_sof_cnt"}, nsof, 1);
    chk({tag, "_eof_cnt"}, neof, 1);
    if (n > 0) begin
      chk({tag, "_sof_first"}, beats[0].sof, 1);
      chk({tag, "_eof_last"}, beats[n-1].eof, 1);
      chk({tag, "_len"}, beats[n-1].len, exp_len);
      chk({tag, "_status"}, beats[n-1].st, exp_st);
    end
    beats.delete();
  endtask

  initial begin
    #25;
    chk("reset_outputs", {m_valid, m_sof, m_eof, m_data, m_status, m_len}, 0);
    @(negedge clk_mac);
    rst = 1'b0;
    send_gap(4);

    // Valid 64-byte frame
    build_frame(60, 3);
    send_frame(0, -1);
    check_frame("good64", 4'b0000, 64);

    // 14-byte runt without FCS
    tx_q.delete();
    for (int i = 0; i < 6; i++) tx_q.push_back(8'hFF);
    for (int i = 0; i < 6; i++) tx_q.push_back(8'h00);
    tx_q.push_back(8'hEB);
    tx_q.push_back(8'hEB);
    send_frame(0, -1);
    check_frame("runt14", 4'b0011, 14);

    // Carrier toggling over the FCS bytes
    build_frame(60, 11);
    send_frame(1, -1);
    check_frame("toggle64", 4'b0000, 64);

    // PHY error pulse mid-frame
    build_frame(60, 29);
    send_frame(0, 30);
    check_frame("rxerr64", 4'b0100, 64);

    // Carrier lost at dibit index 3 after 65 good bytes
    build_frame(61, 5);
    send_preamble();
    for (int i = 0; i < tx_q.size(); i++) send_byte(tx_q[i], 0, 0);
    send_dibit(1'b1, 2'b01, 1'b0);
    send_dibit(1'b1, 2'b10, 1'b0);
    send_dibit(1'b1, 2'b11, 1'b0);
    send_dibit(1'b0, 2'b00, 1'b0);
    send_gap(10);
    check_frame("align65", 4'b1000, 65);

    // Single-byte frame
    tx_q.delete();
    tx_q.push_back(8'hA5);
    send_frame(0, -1);
    check_frame("one_byte", 4'b0011, 1);

    // Bad preamble dibit drops the frame even if SFD-like dibits follow
    for (int i = 0; i < 4; i++) send_dibit(1'b1, 2'b01, 1'b0);
    send_dibit(1'b1, 2'b10, 1'b0);
    for (int i = 0; i < 40; i++) send_dibit(1'b1, 2'b11, 1'b0);
    send_gap(10);
    chk("drop_beats", beats.size(), 0);
    beats.delete();

    // Reset during byte 20: outputs clear at once, no eof, next frame is clean
    build_frame(60, 17);
    send_preamble();
    for (int i = 0; i < 20; i++) send_byte(tx_q[i], 0, 0);
    send_dibit(1'b1, tx_q[20][1:0], 1'b0);
    chk("pre_reset_valid", m_valid, 1);
    #3;
    rst = 1'b1;
    eth_crsdv = 1'b0;
    #1;
    chk("midreset_outputs", {m_valid, m_sof, m_eof, m_data, m_status, m_len}, 0);
    beats.delete();
    repeat (2) @(negedge clk_mac);
    rst = 1'b0;
    send_gap(10);
    chk("midreset_no_eof", beats.size(), 0);
    beats.delete();
    build_frame(60, 41);
    send_frame(0, -1);
    check_frame("after_reset", 4'b0000, 64);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
